id_ex_issue: RTL and testbench
==============================

Name: id_ex_issue

Overview:
- Decode and issue stage that produces the operand/opcode triple consumed by the EX-stage ALU (ID_EX_A, ID_EX_B, 6-bit ALU opcode).
- Accepts RV32 R-type instructions over a valid/ready handshake and reads operands from an internal 32x32 register file.
- Tracks outstanding destinations in a scoreboard to stall on RAW hazards.
- Holds the result in an ID/EX pipeline register until EX accepts it; the writeback port closes the loop.

Parameters:
- XLEN, 32, operand/register width
- NREGS, 32, architectural register count (x0 hardwired zero)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- instr_valid  in  1  fetch presents an instruction
- instr  in  32  RV32 instruction word
- instr_ready  out  1  stage accepts instr this cycle
- ID_EX_A  out  XLEN  operand A (rs1 value) to ALU
- ID_EX_B  out  XLEN  operand B (rs2 value) to ALU
- opcode  out  6  ALU opcode
- ex_rd  out  5  destination register tag travelling with the op
- ex_valid  out  1  ID/EX register holds a valid op
- ex_ready  in  1  EX consumes op this cycle
- wb_en  in  1  writeback strobe
- wb_rd  in  5  writeback destination
- wb_data  in  XLEN  writeback value
- illegal  out  1  one-cycle pulse: accepted instruction was not decodable

Behaviour:
- Reset (rst_n=0 at clk edge): ex_valid=0, ID_EX_A=ID_EX_B=0, opcode=0, ex_rd=0, illegal=0, scoreboard all clear, register file all zero. Any in-flight op is dropped. instr_ready is combinational and reads 0 while rst_n=0.
- Decode is legal only when instr[6:0]=0110011. Legal (funct7, funct3) mappings:
  - 0000000/000 -> ADD 000000
  - 0100000/000 -> SUB 000001
  - 0000000/111 -> AND 000010
  - 0000000/110 -> OR 000011
  - 0000000/010 -> SLT 000100
  - 0000001/000 -> MUL 000101
  - Anything else is illegal.
- Fields: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
- Hazard (legal instructions only): sb[rs1] set and rs1!=0, or sb[rs2] set and rs2!=0, unless the same cycle has wb_en=1 with wb_rd equal to that rs (bypass).
- instr_ready = (~ex_valid | ex_ready) & ~hazard. This is a combinational path from instr and the wb_* inputs.
- Accept = instr_valid & instr_ready. For a legal accepted instruction, on the next edge:
  - ex_valid=1; opcode and ex_rd are loaded.
  - ID_EX_A/B are loaded with the operand value. x0 reads 0. A same-cycle wb to a matching nonzero register forwards wb_data, otherwise the regfile value is used.
  - If rd!=0, sb[rd] is set.
- For an illegal accepted instruction: consumed, illegal=1 for exactly one cycle, no issue, no scoreboard change. ex_valid falls if ex_ready drained the old op.
- If ex_valid & ex_ready and there is no new accept, ex_valid goes to 0 next cycle. Data outputs hold their last values.
- While ex_valid=1 and ex_ready=0, all ID/EX outputs hold stable, and instr_ready=0.
- Latency: accept at cycle N gives ex_valid at N+1. Throughput is 1 op/cycle when ex_ready is held at 1 and there are no hazards.
- Writeback: wb_en with wb_rd!=0 writes regfile[wb_rd] and clears sb[wb_rd]. wb_rd=0 is ignored.
- Simultaneous clear and set of the same register: set wins, because the new producer is now outstanding.
- Scoreboard allows one outstanding write per register. Issuing a WAW to a pending rd is permitted; sb simply stays set.
- ALU semantics, including SLT, are owned by EX. This block only encodes them.

Decomposition:
- Shared package holds:
  - ALU opcode constants ADD..MUL, with values identical to the EX ALU.
  - RV32 R-type opcode 0110011.
  - funct3/funct7 constants.
  - XLEN.
- One natural sub-module: regfile_2r1w, with 2 async read ports, 1 sync write port, x0 reads zero, and synchronous active-low reset clear.
- Decoder, scoreboard and ID/EX register stay in the top.

Test Plan:
- Reset, then wb x1=5 and x2=3, then issue add x3,x1,x2 (0x002081B3) with ex_ready=1 -> next cycle ex_valid=1, opcode=000000, A=5, B=3, ex_rd=3.
- With sb[3] set, issue sub x4,x3,x1 -> instr_ready=0 until wb x3=8. In that wb cycle the op is accepted and forwarded: A=8, B=5, opcode=000001.
- Hold ex_ready=0 with an op pending -> outputs stable for 4 cycles and instr_ready=0. Raise ex_ready -> the next instruction is accepted the same cycle.
- Issue 0x0000007F (bad opcode) and funct7=0100000/funct3=111 -> illegal pulses 1 cycle each, ex_valid stays 0, scoreboard unchanged.
- mul x5,x0,x2 with x2=7 -> A=0, B=7, opcode=000101. Then wb to x0 with 0xFFFFFFFF -> a later read of x0 still gives 0.
- Assert rst_n=0 for 1 cycle while ex_valid=1 and sb[3]=1 -> ex_valid=0, sb clear, regfile zero. An instruction reading x3 then issues with no stall.

Source files
------------

// File: rtl/id_ex_issue_pkg.sv
// Shared constants, types and the R-type decode helper for the ID/EX issue stage.
package id_ex_issue_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_SLT     = 3'b010;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] F7_MULDIV  = 7'b0000001;

  // Opcode values must stay identical to the EX-stage ALU encoding.
  typedef enum logic [5:0] {
    ALU_ADD = 6'b000000,
    ALU_SUB = 6'b000001,
    ALU_AND = 6'b000010,
    ALU_OR  = 6'b000011,
    ALU_SLT = 6'b000100,
    ALU_MUL = 6'b000101
  } alu_op_e;

  typedef struct packed {
    logic    legal;
    alu_op_e op;
  } decode_t;

  // Maps an instruction word to an ALU opcode; anything outside the supported
  // R-type subset comes back with legal cleared.
  function automatic decode_t decode_rtype(input logic [31:0] ins);
    decode_t d;
    d.legal = 1'b0;
    d.op    = ALU_ADD;
    if (ins[6:0] == OPC_RTYPE) begin
      d.legal = 1'b1;
      case ({ins[31:25], ins[14:12]})
        {F7_BASE,   F3_ADD_SUB}: d.op = ALU_ADD;
        {F7_ALT,    F3_ADD_SUB}: d.op = ALU_SUB;
        {F7_BASE,   F3_AND}:     d.op = ALU_AND;
        {F7_BASE,   F3_OR}:      d.op = ALU_OR;
        {F7_BASE,   F3_SLT}:     d.op = ALU_SLT;
        {F7_MULDIV, F3_ADD_SUB}: d.op = ALU_MUL;
        default:                 d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/id_ex_issue_if.sv
// Fetch, EX and writeback signals of the issue stage; master is the pipeline
// environment, slave is the issue stage itself.
interface id_ex_issue_if;
  import id_ex_issue_pkg::*;

  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  logic [XLEN-1:0] ID_EX_A;
  logic [XLEN-1:0] ID_EX_B;
  logic [5:0]      opcode;
  logic [4:0]      ex_rd;
  logic            ex_valid;
  logic            ex_ready;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;

  modport master (
    output instr_valid, instr, ex_ready, wb_en, wb_rd, wb_data,
    input  instr_ready, ID_EX_A, ID_EX_B, opcode, ex_rd, ex_valid, illegal
  );

  modport slave (
    input  instr_valid, instr, ex_ready, wb_en, wb_rd, wb_data,
    output instr_ready, ID_EX_A, ID_EX_B, opcode, ex_rd, ex_valid, illegal
  );

endinterface

// File: rtl/id_ex_issue_regfile.sv
// Architectural register file: two asynchronous reads, one synchronous write,
// x0 hardwired to zero.
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  input  logic [$clog2(NREGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  input  logic                     we,
  input  logic [$clog2(NREGS)-1:0] wa,
  input  logic [XLEN-1:0]          wd
);

  logic [XLEN-1:0] regs [NREGS];

  // Clear everything on reset; writes to x0 are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/id_ex_issue.sv
// Decode/issue stage: decodes R-type ops, stalls on RAW hazards via a
// scoreboard, and holds the operand/opcode triple until EX takes it.
module id_ex_issue #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_issue_if.slave bus
);
  import id_ex_issue_pkg::*;

  logic [4:0]      rs1, rs2, rd;
  decode_t         dec;
  logic [XLEN-1:0] rf_a, rf_b;
  logic [XLEN-1:0] opnd_a, opnd_b;
  logic [NREGS-1:0] sb;
  logic            haz1, haz2, hazard;
  logic            ready, accept, issue;

  logic            ex_valid_q, illegal_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [5:0]      op_q;
  logic [4:0]      rd_q;

  assign rs1 = bus.instr[19:15];
  assign rs2 = bus.instr[24:20];
  assign rd  = bus.instr[11:7];
  assign dec = decode_rtype(bus.instr);

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rs1_data (rf_a),
    .rs2_data (rf_b),
    .we       (bus.wb_en),
    .wa       (bus.wb_rd),
    .wd       (bus.wb_data)
  );

  // Hazard detection with same-cycle writeback bypass, plus operand forwarding.
  always_comb begin
    haz1   = sb[rs1] && (rs1 != 5'd0) && !(bus.wb_en && (bus.wb_rd == rs1));
    haz2   = sb[rs2] && (rs2 != 5'd0) && !(bus.wb_en && (bus.wb_rd == rs2));
    hazard = dec.legal && (haz1 || haz2);
    opnd_a = rf_a;
    opnd_b = rf_b;
    if (rs1 == 5'd0)                                opnd_a = '0;
    else if (bus.wb_en && (bus.wb_rd == rs1))       opnd_a = bus.wb_data;
    if (rs2 == 5'd0)                                opnd_b = '0;
    else if (bus.wb_en && (bus.wb_rd == rs2))       opnd_b = bus.wb_data;
  end

  assign ready  = rst_n && (!ex_valid_q || bus.ex_ready) && !hazard;
  assign accept = bus.instr_valid && ready;
  assign issue  = accept && dec.legal;

  // ID/EX register: load on a legal accept, drain when EX consumes, else hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rd_q       <= '0;
    end else begin
      illegal_q <= accept && !dec.legal;
      if (issue) begin
        ex_valid_q <= 1'b1;
        a_q        <= opnd_a;
        b_q        <= opnd_b;
        op_q       <= dec.op;
        rd_q       <= rd;
      end else if (ex_valid_q && bus.ex_ready) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  // Scoreboard: writeback clears, a new issue sets; set is applied last so it wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      if (bus.wb_en && (bus.wb_rd != 5'd0)) sb[bus.wb_rd] <= 1'b0;
      if (issue && (rd != 5'd0))            sb[rd]        <= 1'b1;
    end
  end

  assign bus.instr_ready = ready;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.ID_EX_A     = a_q;
  assign bus.ID_EX_B     = b_q;
  assign bus.opcode      = op_q;
  assign bus.ex_rd       = rd_q;
  assign bus.illegal     = illegal_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// Directed, table-driven self-checking bench for the ID/EX issue stage.
module tb_id_ex_issue;

  logic clk;
  logic rst_n;
  int   tests;
  int   failures;

  id_ex_issue_if bus ();

  id_ex_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        valid;
    logic [31:0] instr;
    logic        ex_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        exp_ready;
    logic        exp_valid;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [5:0]  exp_op;
    logic [4:0]  exp_rd;
    logic        exp_illegal;
  } vec_t;

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] s2,
                                        input logic [4:0] s1, input logic [2:0] f3,
                                        input logic [4:0] d);
    return {f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] ins,
                              input logic er, input logic we, input logic [4:0] wr,
                              input logic [31:0] wd, input logic xr, input logic xv,
                              input logic [31:0] xa, input logic [31:0] xb,
                              input logic [5:0] xo, input logic [4:0] xd, input logic xi);
    vec_t t;
    t.rst_n = r; t.valid = v; t.instr = ins; t.ex_ready = er;
    t.wb_en = we; t.wb_rd = wr; t.wb_data = wd;
    t.exp_ready = xr; t.exp_valid = xv; t.exp_a = xa; t.exp_b = xb;
    t.exp_op = xo; t.exp_rd = xd; t.exp_illegal = xi;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check instr_ready before the
  // rising edge and the registered outputs just after it.
  task automatic applyStimulus(input vec_t t, input string tag);
    @(negedge clk);
    rst_n           = t.rst_n;
    bus.instr_valid = t.valid;
    bus.instr       = t.instr;
    bus.ex_ready    = t.ex_ready;
    bus.wb_en       = t.wb_en;
    bus.wb_rd       = t.wb_rd;
    bus.wb_data     = t.wb_data;
    #1;
    checkOutput({tag, " instr_ready"}, {31'd0, bus.instr_ready}, {31'd0, t.exp_ready});
    @(posedge clk);
    #1;
    checkOutput({tag, " ex_valid"}, {31'd0, bus.ex_valid}, {31'd0, t.exp_valid});
    checkOutput({tag, " ID_EX_A"},  bus.ID_EX_A, t.exp_a);
    checkOutput({tag, " ID_EX_B"},  bus.ID_EX_B, t.exp_b);
    checkOutput({tag, " opcode"},   {26'd0, bus.opcode}, {26'd0, t.exp_op});
    checkOutput({tag, " ex_rd"},    {27'd0, bus.ex_rd}, {27'd0, t.exp_rd});
    checkOutput({tag, " illegal"},  {31'd0, bus.illegal}, {31'd0, t.exp_illegal});
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] add3, sub4, or6, bad7, and8, mul5, slt9, add10;
    tests    = 0;
    failures = 0;
    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.ex_ready    = 1'b0;
    bus.wb_en       = 1'b0;
    bus.wb_rd       = '0;
    bus.wb_data     = '0;

    add3  = 32'h002081B3;
    sub4  = rtype(7'b0100000, 5'd1, 5'd3, 3'b000, 5'd4);
    or6   = rtype(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd6);
    bad7  = rtype(7'b0100000, 5'd2, 5'd1, 3'b111, 5'd7);
    and8  = rtype(7'b0000000, 5'd1, 5'd7, 3'b111, 5'd8);
    mul5  = rtype(7'b0000001, 5'd2, 5'd0, 3'b000, 5'd5);
    slt9  = rtype(7'b0000000, 5'd0, 5'd0, 3'b010, 5'd9);
    add10 = rtype(7'b0000000, 5'd2, 5'd0, 3'b000, 5'd10);

    // reset with a valid instruction present: not ready, everything cleared
    vecs.push_back(mk(0, 1, add3, 1, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, add3, 1, 0, 0, 0,          0, 0, 0, 0, 0, 0, 0));
    // wb x1=5, x2=3, then add x3,x1,x2
    vecs.push_back(mk(1, 0, 0,    1, 1, 1, 5,          1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,    1, 1, 2, 3,          1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, add3, 1, 0, 0, 0,          1, 1, 5, 3, 0, 3, 0));
    // sub x4,x3,x1 stalls on x3 until wb x3=8 bypasses it
    vecs.push_back(mk(1, 1, sub4, 1, 0, 0, 0,          0, 0, 5, 3, 0, 3, 0));
    vecs.push_back(mk(1, 1, sub4, 1, 0, 0, 0,          0, 0, 5, 3, 0, 3, 0));
    vecs.push_back(mk(1, 1, sub4, 1, 1, 3, 8,          1, 1, 8, 5, 1, 4, 0));
    // EX back-pressure for 4 cycles, then release accepts or x6 the same cycle
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 1, or6, 0, 0, 0, 0,         0, 1, 8, 5, 1, 4, 0));
    vecs.push_back(mk(1, 1, or6,  1, 0, 0, 0,          1, 1, 5, 3, 3, 6, 0));
    // drain, retire x4 and x6
    vecs.push_back(mk(1, 0, 0,    1, 1, 4, 32'h11,     1, 0, 5, 3, 3, 6, 0));
    vecs.push_back(mk(1, 0, 0,    1, 1, 6, 32'h22,     1, 0, 5, 3, 3, 6, 0));
    // illegal encodings pulse for one cycle
    vecs.push_back(mk(1, 1, 32'h0000007F, 1, 0, 0, 0,  1, 0, 5, 3, 3, 6, 1));
    vecs.push_back(mk(1, 0, 0,    1, 0, 0, 0,          1, 0, 5, 3, 3, 6, 0));
    vecs.push_back(mk(1, 1, bad7, 1, 0, 0, 0,          1, 0, 5, 3, 3, 6, 1));
    vecs.push_back(mk(1, 0, 0,    1, 0, 0, 0,          1, 0, 5, 3, 3, 6, 0));
    // x7 not marked by the illegal op: and x8,x7,x1 issues at once
    vecs.push_back(mk(1, 1, and8, 1, 0, 0, 0,          1, 1, 0, 5, 2, 8, 0));
    // mul x5,x0,x2 with x2=7 forwarded, back to back
    vecs.push_back(mk(1, 1, mul5, 1, 1, 2, 7,          1, 1, 0, 7, 5, 5, 0));
    // wb to x0 must neither forward nor stick
    vecs.push_back(mk(1, 1, slt9, 1, 1, 0, 32'hFFFFFFFF, 1, 1, 0, 0, 4, 9, 0));
    vecs.push_back(mk(1, 1, add10, 1, 0, 0, 0,         1, 1, 0, 7, 0, 10, 0));

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset while an op is held and sb[3] is pending, then x3 reads without stall.
    applyStimulus(mk(1, 1, add3, 1, 0, 0, 0,           1, 1, 5, 7, 0, 3, 0), "rst_issue");
    applyStimulus(mk(1, 0, 0,    0, 0, 0, 0,           0, 1, 5, 7, 0, 3, 0), "rst_hold");
    applyStimulus(mk(0, 1, sub4, 0, 0, 0, 0,           0, 0, 0, 0, 0, 0, 0), "rst_pulse");
    applyStimulus(mk(1, 1, sub4, 1, 0, 0, 0,           1, 1, 0, 0, 1, 4, 0), "rst_after");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
